// File: rtl/ft232h_rx.sv
// ft232h_rx: FT232H sync-245 FIFO receive engine buffering host bytes onto an AXI-Stream source.
// Define FT232H_RX_STATS_EN to add the rx_byte_count output.
module ft232h_rx #(
  parameter int DEPTH = 4
) (
  input  logic        ftdi_clk,
  input  logic        rst,
  input  logic        ftdi_rxf_n,
  input  logic [7:0]  ftdi_adbus_i,
  output logic        ftdi_rd_n,
  output logic        ftdi_oe_n,
  output logic        ftdi_siwu_n,
  output logic        adbus_release,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
`ifdef FT232H_RX_STATS_EN
  ,
  output logic [31:0] rx_byte_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH - 2);
  typedef enum logic [1:0] {IDLE, TURN, READ, HOLD} state_t;
  state_t state, state_nx;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nx;
  logic push, pop;
  assign push = !ftdi_rd_n && !ftdi_rxf_n;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign count_nx = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign m_axis_tvalid = count != '0;
  assign m_axis_tdata = mem[rd_ptr];
  assign ftdi_siwu_n = 1'b1;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = (!ftdi_rxf_n && count <= LIM) ? TURN : IDLE;
      TURN: state_nx = READ;
      READ: state_nx = (!ftdi_rxf_n && count_nx < FULL) ? READ : HOLD;
      HOLD: state_nx = IDLE;
    endcase
  end
  // Bus controls are registered from the next state so they change on the state edge.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      state <= IDLE;
      ftdi_rd_n <= 1'b1;
      ftdi_oe_n <= 1'b1;
      adbus_release <= 1'b0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      assert (!(push && !pop && count == FULL)) else $error("ft232h_rx: fifo overflow");
      state <= state_nx;
      ftdi_rd_n <= state_nx != READ;
      ftdi_oe_n <= !(state_nx == TURN || state_nx == READ);
      adbus_release <= state_nx != IDLE;
      count <= count_nx;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
    end
  end
  always_ff @(posedge ftdi_clk) begin
    if (push) mem[wr_ptr] <= ftdi_adbus_i;
  end
`ifdef FT232H_RX_STATS_EN
  always_ff @(posedge ftdi_clk) begin
    if (rst) rx_byte_count <= '0;
    else if (push) rx_byte_count <= rx_byte_count + 32'd1;
  end
`endif
endmodule
